// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-map controller: FSM encoding and
// clock-domain crossing constants.
package i2c_pkg;

    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned CLK_RATIO  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        FETCH_CAP = 3'd2,
        WAIT_BYTE = 3'd3,
        WRITE     = 3'd4
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one SCL-domain level, with rise/fall pulses
// derived from one extra history flop.
module sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign level  = sync_q[SYNC_DEPTH-1];
    assign rise_c = sync_q[SYNC_DEPTH-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_DEPTH-1] & prev_q;

endmodule

// File: rtl/i2c_regmap_ctrl.sv
// Sequences the byte stream of an I2C slave onto a small register file:
// pointer decode, register writes, prefetched reads with auto-increment.
module i2c_regmap_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    input  logic              i2c_start,
    input  logic              i2c_stop,
    input  logic              i2c_r_w,
    input  logic              i2c_data_vld,
    input  logic [7:0]        i2c_data_out,
    output logic [7:0]        i2c_data_in,
    output logic              i2c_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              wr_done
);

    logic start_rise;
    logic stop_rise;
    logic byte_evt;
    logic r_w_s;
    logic [4:0] edges_unused;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              first;
    logic              wr_seen;

    sync_edge u_sync_start (
        .clk    (clk),
        .rstb   (rstb),
        .d      (i2c_start),
        .level  (edges_unused[0]),
        .rise_c (start_rise),
        .fall_c (edges_unused[1])
    );

    sync_edge u_sync_stop (
        .clk    (clk),
        .rstb   (rstb),
        .d      (i2c_stop),
        .level  (edges_unused[2]),
        .rise_c (stop_rise),
        .fall_c (edges_unused[3])
    );

    sync_edge u_sync_r_w (
        .clk    (clk),
        .rstb   (rstb),
        .d      (i2c_r_w),
        .level  (r_w_s),
        .rise_c (),
        .fall_c ()
    );

    // data_out changes on the same SCL edge that drops data_vld
    sync_edge u_sync_vld (
        .clk    (clk),
        .rstb   (rstb),
        .d      (i2c_data_vld),
        .level  (),
        .rise_c (edges_unused[4]),
        .fall_c (byte_evt)
    );

    // Strobes and reg_addr are loaded on the edge entering FETCH/WRITE so they
    // are valid for exactly the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            ptr         <= '0;
            first       <= 1'b0;
            wr_seen     <= 1'b0;
            i2c_data_in <= 8'h00;
            i2c_ready   <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            wr_done <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                i2c_ready <= 1'b0;
            end else if (state == IDLE) begin
                i2c_ready <= 1'b1;
                if (start_rise) begin
                    state     <= FETCH;
                    first     <= 1'b1;
                    wr_seen   <= 1'b0;
                    reg_re    <= 1'b1;
                    reg_addr  <= ptr;
                    i2c_ready <= 1'b0;
                end
            end else if (stop_rise) begin
                state     <= IDLE;
                wr_done   <= wr_seen;
                i2c_ready <= 1'b1;
            end else if (start_rise) begin
                state     <= FETCH;
                first     <= 1'b1;
                reg_re    <= 1'b1;
                reg_addr  <= ptr;
                i2c_ready <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        state     <= FETCH_CAP;
                        i2c_ready <= 1'b0;
                    end
                    FETCH_CAP: begin
                        i2c_data_in <= reg_rdata;
                        state       <= WAIT_BYTE;
                        i2c_ready   <= 1'b1;
                    end
                    WAIT_BYTE: begin
                        if (byte_evt) begin
                            if (r_w_s) begin
                                ptr       <= ptr + ADDR_W'(1);
                                state     <= FETCH;
                                reg_re    <= 1'b1;
                                reg_addr  <= ptr + ADDR_W'(1);
                                i2c_ready <= 1'b0;
                            end else if (first) begin
                                ptr       <= i2c_data_out[ADDR_W-1:0];
                                first     <= 1'b0;
                                state     <= FETCH;
                                reg_re    <= 1'b1;
                                reg_addr  <= i2c_data_out[ADDR_W-1:0];
                                i2c_ready <= 1'b0;
                            end else begin
                                state     <= WRITE;
                                reg_we    <= 1'b1;
                                reg_addr  <= ptr;
                                reg_wdata <= i2c_data_out;
                                ptr       <= ptr + ADDR_W'(1);
                                wr_seen   <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        state     <= FETCH;
                        reg_re    <= 1'b1;
                        reg_addr  <= ptr;
                        i2c_ready <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        i2c_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_regmap_ctrl.sv
// Directed bench for i2c_regmap_ctrl with a behavioural register file and
// abstracted slave handshake pulses.
module tb_i2c_regmap_ctrl;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       en = 1'b1;
    logic       i2c_start = 1'b0;
    logic       i2c_stop = 1'b0;
    logic       i2c_r_w = 1'b0;
    logic       i2c_data_vld = 1'b0;
    logic [7:0] i2c_data_out = 8'h00;
    logic [7:0] i2c_data_in;
    logic       i2c_ready;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       wr_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];
    logic       mem_loaded = 1'b0;

    int         we_cnt = 0;
    int         re_cnt = 0;
    int         done_cnt = 0;
    int         both_cnt = 0;
    int         we_long = 0;
    logic       we_prev = 1'b0;
    logic [3:0] we_addr_log [8];
    logic [7:0] we_data_log [8];
    int         low_run = 0;
    int         last_low_run = 0;
    int         re_before;

    i2c_regmap_ctrl #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .en           (en),
        .i2c_start    (i2c_start),
        .i2c_stop     (i2c_stop),
        .i2c_r_w      (i2c_r_w),
        .i2c_data_vld (i2c_data_vld),
        .i2c_data_out (i2c_data_out),
        .i2c_data_in  (i2c_data_in),
        .i2c_ready    (i2c_ready),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .wr_done      (wr_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        if (i == 15) return 8'h11;
        if (i == 0)  return 8'h22;
        if (i == 1)  return 8'h33;
        return 8'(i);
    endfunction

    // Register file: rdata valid the cycle after reg_re
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else begin
            if (reg_we) mem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= mem[reg_addr];
        end
    end

    always @(negedge clk) begin
        if (reg_we) begin
            if (we_cnt < 8) begin
                we_addr_log[we_cnt] = reg_addr;
                we_data_log[we_cnt] = reg_wdata;
            end
            we_cnt++;
        end
        if (reg_we && we_prev) we_long++;
        we_prev = reg_we;
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) both_cnt++;
        if (wr_done) done_cnt++;
        if (rstb && en) begin
            if (!i2c_ready) low_run++;
            else if (low_run != 0) begin
                last_low_run = low_run;
                low_run = 0;
            end
        end else begin
            low_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        i2c_start = 1'b1;
        cyc(CLK_RATIO / 2);
        i2c_start = 1'b0;
        cyc(4);
    endtask

    task automatic pulse_stop();
        i2c_stop = 1'b1;
        cyc(CLK_RATIO / 2);
        i2c_stop = 1'b0;
        cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i2c_data_vld = 1'b1;
        cyc(6);
        i2c_data_out = b;
        i2c_data_vld = 1'b0;
        cyc(12);
    endtask

    initial begin
        // Reset
        cyc(3);
        chk("rst_data_in", i2c_data_in, 8'h00);
        chk("rst_ready", 8'(i2c_ready), 8'h00);
        chk("rst_addr", 8'(reg_addr), 8'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_we", 8'(reg_we), 8'h00);
        chk("rst_re", 8'(reg_re), 8'h00);
        chk("rst_wr_done", 8'(wr_done), 8'h00);
        chk("rst_ptr", 8'(dut.ptr), 8'h00);
        rstb = 1'b1;
        cyc(3);
        chk("idle_ready", 8'(i2c_ready), 8'h01);

        // Write: pointer 0x03, data A5, 5A
        i2c_r_w = 1'b0;
        pulse_start();
        chk("wr_prefetch0", i2c_data_in, 8'h22);
        send_byte(8'h03);
        chk("wr_ptr_load", 8'(dut.ptr), 8'h03);
        send_byte(8'hA5);
        send_byte(8'h5A);
        pulse_stop();
        chk("wr_we_cnt", 8'(we_cnt), 8'd2);
        chk("wr_addr0", 8'(we_addr_log[0]), 8'h03);
        chk("wr_data0", we_data_log[0], 8'hA5);
        chk("wr_addr1", 8'(we_addr_log[1]), 8'h04);
        chk("wr_data1", we_data_log[1], 8'h5A);
        chk("wr_done_cnt", 8'(done_cnt), 8'd1);
        chk("wr_ptr_end", 8'(dut.ptr), 8'h05);

        // Repeated-start read across the wrap
        pulse_start();
        send_byte(8'h0F);
        i2c_r_w = 1'b1;
        cyc(4);
        pulse_start();
        chk("rd_byte0", i2c_data_in, 8'h11);
        chk("rd_ptr15", 8'(dut.ptr), 8'h0F);
        send_byte(8'h00);
        chk("rd_wrap_ptr", 8'(dut.ptr), 8'h00);
        chk("rd_byte1", i2c_data_in, 8'h22);
        send_byte(8'h00);
        chk("rd_ptr_after", 8'(dut.ptr), 8'h01);
        pulse_stop();
        chk("rd_no_we", 8'(we_cnt), 8'd2);
        chk("rd_no_done", 8'(done_cnt), 8'd1);

        // Back-to-back read from retained pointer
        re_before = re_cnt;
        pulse_start();
        chk("b2b_addr", 8'(reg_addr), 8'h01);
        chk("b2b_data", i2c_data_in, 8'h33);
        chk("b2b_re_cnt", 8'(re_cnt - re_before), 8'd1);
        chk("b2b_ready_low", 8'(last_low_run), 8'd2);
        pulse_stop();

        // Simultaneous stop and byte event
        i2c_r_w = 1'b0;
        cyc(4);
        pulse_start();
        send_byte(8'h08);
        i2c_data_vld = 1'b1;
        cyc(6);
        i2c_data_out = 8'h99;
        i2c_data_vld = 1'b0;
        i2c_stop = 1'b1;
        cyc(12);
        i2c_stop = 1'b0;
        cyc(4);
        chk("sim_state", 8'(dut.state), 8'(IDLE));
        chk("sim_no_we", 8'(we_cnt), 8'd2);
        chk("sim_mem8", mem[8], 8'h08);
        chk("sim_no_done", 8'(done_cnt), 8'd1);

        // Enable dropped mid-write; upper pointer bits ignored
        pulse_start();
        send_byte(8'h72);
        chk("en_ptr_load", 8'(dut.ptr), 8'h02);
        en = 1'b0;
        cyc(1);
        chk("en_ready", 8'(i2c_ready), 8'h00);
        chk("en_state", 8'(dut.state), 8'(IDLE));
        chk("en_ptr_kept", 8'(dut.ptr), 8'h02);
        cyc(2);
        en = 1'b1;
        pulse_stop();

        // Reset in the middle of a read
        i2c_r_w = 1'b1;
        cyc(4);
        pulse_start();
        chk("mr_prefetch", i2c_data_in, 8'h02);
        rstb = 1'b0;
        cyc(1);
        chk("mr_state", 8'(dut.state), 8'(IDLE));
        chk("mr_ptr", 8'(dut.ptr), 8'h00);
        chk("mr_re", 8'(reg_re), 8'h00);
        chk("mr_we", 8'(reg_we), 8'h00);
        chk("mr_data_in", i2c_data_in, 8'h00);
        rstb = 1'b1;
        pulse_stop();

        chk("end_done_cnt", 8'(done_cnt), 8'd1);
        chk("end_both", 8'(both_cnt), 8'd0);
        chk("end_we_width", 8'(we_long), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
